// File: rtl/ironhorse_audio_pkg.sv
// Shared audio-path definitions for the Iron Horse sound blocks: Q15 format,
// sample limits, filter sequencing states and the 16-bit saturator.
package ironhorse_audio_pkg;

  localparam int Q15_FRAC = 15;

  localparam logic signed [15:0] SAMPLE_MAX = 16'sh7fff;
  localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_ACC   = 2'd2,
    ST_WRITE = 2'd3
  } hpf_state_e;

  // Clamp a wide signed intermediate into the 16-bit sample range.
  function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
    if (v > 34'sd32767) begin
      return SAMPLE_MAX;
    end else if (v < -34'sd32768) begin
      return SAMPLE_MIN;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/audio_sample_div.sv
// Free-running sample-rate divider; tick is high while the count is zero,
// so the first clock after reset is already a sample tick.
module audio_sample_div #(
  parameter int DIV = 256
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == CW'(DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = (div_cnt == '0);

endmodule

// File: rtl/ironhorse_ssg_hpf.sv
// First-order DC-blocking high-pass: y[n] = x[n] - x[n-1] + A*y[n-1],
// sequenced over four states so a single multiplier serves each sample.
module ironhorse_ssg_hpf
  import ironhorse_audio_pkg::*;
#(
  parameter int DIV    = 256,
  parameter int COEF_A = 32736
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] in,
  output logic signed [15:0] out,
  output logic               out_valid
);

  // Coefficient is unsigned Q15 below 1.0, so bit 15 is zero and the
  // signed view equals the zero-extended value.
  localparam logic signed [15:0] COEF_S = 16'(COEF_A);

  logic tick;

  hpf_state_e         state;
  logic signed [15:0] x_cur;
  logic signed [15:0] x_prev;
  logic signed [15:0] y_prev;
  logic signed [31:0] prod;
  logic signed [33:0] acc;

  logic signed [33:0] x_cur_w;
  logic signed [33:0] x_prev_w;
  logic signed [33:0] prod_w;
  logic signed [15:0] sat;

  audio_sample_div #(.DIV(DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign x_cur_w  = 34'(x_cur);
  assign x_prev_w = 34'(x_prev);
  assign prod_w   = 34'(prod);
  assign sat      = sat16(acc);

  // NOTE: every register here is written with <= so all state updates on an
  // edge see the values from before that edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      x_cur     <= '0;
      x_prev    <= '0;
      y_prev    <= '0;
      prod      <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            x_cur <= in;
            state <= ST_MUL;
          end
        end
        ST_MUL: begin
          prod  <= 32'(y_prev) * 32'(COEF_S);
          state <= ST_ACC;
        end
        ST_ACC: begin
          // Arithmetic shift floors toward minus infinity; no rounding term.
          acc   <= x_cur_w - x_prev_w + (prod_w >>> Q15_FRAC);
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          out       <= sat;
          y_prev    <= sat;
          x_prev    <= x_cur;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ironhorse_ssg_hpf.sv
// Scoreboard bench for ironhorse_ssg_hpf: a reference model pushes expected
// samples as inputs are presented; a monitor pops them on each out_valid.
module tb_ironhorse_ssg_hpf;

  localparam int DIV    = 256;
  localparam int COEF_A = 32736;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] in;
  logic signed [15:0] out;
  logic               out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [15:0] exp_q[$];
  logic signed [15:0] obs_q[$];

  longint m_xprev = 0;
  longint m_yprev = 0;

  always #5 clk = ~clk;

  ironhorse_ssg_hpf #(.DIV(DIV), .COEF_A(COEF_A)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .out       (out),
    .out_valid (out_valid)
  );

  initial begin : div_guard
    assert (DIV >= 4) else $error("DIV below 4 is unsupported");
  end

  function automatic logic signed [15:0] model_step(input logic signed [15:0] x);
    longint a;
    longint s;
    a = longint'(x) - m_xprev + ((m_yprev * COEF_A) >>> 15);
    if (a > 32767) s = 32767;
    else if (a < -32768) s = -32768;
    else s = a;
    m_xprev = longint'(x);
    m_yprev = s;
    return 16'(s);
  endfunction

  task automatic model_clear();
    m_xprev = 0;
    m_yprev = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // Runs for the whole simulation; compares every output pulse and its spacing.
  task automatic monitor();
    longint cyc = 0;
    longint last_pulse = 0;
    bit have_last = 1'b0;
    logic signed [15:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset !== 1'b0) begin
        have_last = 1'b0;
      end else if (out_valid === 1'b1) begin
        if (have_last) begin
          n_checks++;
          if (cyc - last_pulse != DIV) begin
            n_fail++;
            $display("FAIL cadence: got %0d clocks between pulses, want %0d", cyc - last_pulse, DIV);
          end
        end
        have_last  = 1'b1;
        last_pulse = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: out_valid with out=%0d, no sample expected", out);
        end else begin
          e = exp_q.pop_front();
          if (out !== e) begin
            n_fail++;
            $display("FAIL sample: got out=%0d, want %0d", out, e);
          end
        end
        obs_q.push_back(out);
      end
    end
  endtask

  // Called at a negedge whose next posedge is a sample tick; returns at the
  // negedge preceding the following tick.
  task automatic run_sample(input logic signed [15:0] v, input bit toggle);
    in = v;
    exp_q.push_back(model_step(v));
    for (int i = 0; i < DIV; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (toggle && i < DIV - 1) in = ~in;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    model_clear();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in    = 16'sd1234;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out !== 16'sd0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got out=%0d out_valid=%b, want 0/0", out, out_valid);
      end
    end
    model_clear();
    reset = 1'b0;
    exp_q.push_back(model_step(16'sd1234));
    for (int i = 0; i < DIV; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 2) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_latency_early: got out_valid=%b after 3 clocks, want 0", out_valid);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (out_valid !== 1'b1 || out !== 16'sd1234) begin
          n_fail++;
          $display("FAIL reset_latency: got out_valid=%b out=%0d after 4 clocks, want 1/1234",
                   out_valid, out);
        end
      end
    end
  endtask

  task automatic test_step();
    bit mono_ok = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) run_sample(16'sd10000, 1'b0);
    n_checks++;
    if (obs_q.size() != 20) begin
      n_fail++;
      $display("FAIL step_count: got %0d outputs, want 20", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0] !== 16'sd10000) begin
        n_fail++;
        $display("FAIL step_s0: got %0d, want 10000", obs_q[0]);
      end
      n_checks++;
      if (obs_q[1] !== 16'sd9990) begin
        n_fail++;
        $display("FAIL step_s1: got %0d, want 9990", obs_q[1]);
      end
      for (int i = 1; i < 20; i++)
        if (obs_q[i] > obs_q[i-1] || obs_q[i] < 0) mono_ok = 1'b0;
      n_checks++;
      if (!mono_ok) begin
        n_fail++;
        $display("FAIL step_decay: got non-monotonic or negative output, want decay to 0");
      end
    end
  endtask

  task automatic test_zero();
    bit zero_ok = 1'b1;
    do_reset();
    for (int i = 0; i < 40; i++) run_sample(16'sd0, 1'b0);
    foreach (obs_q[i]) if (obs_q[i] !== 16'sd0) zero_ok = 1'b0;
    n_checks++;
    if (!zero_ok || obs_q.size() != 40) begin
      n_fail++;
      $display("FAIL zero_input: got %0d outputs with nonzero=%0d, want 40 zeros",
               obs_q.size(), !zero_ok);
    end
  endtask

  task automatic test_pos_sat();
    for (int i = 0; i < 3; i++) run_sample(-16'sd32768, 1'b0);
    obs_q.delete();
    run_sample(16'sd32767, 1'b0);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 16'sd32767) begin
      n_fail++;
      $display("FAIL pos_sat: got %0d outputs, first=%0d, want 32767",
               obs_q.size(), (obs_q.size() != 0) ? obs_q[0] : 16'sd0);
    end
  endtask

  task automatic test_neg_sat();
    for (int i = 0; i < 3; i++) run_sample(16'sd32767, 1'b0);
    obs_q.delete();
    run_sample(-16'sd32768, 1'b0);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== -16'sd32768) begin
      n_fail++;
      $display("FAIL neg_sat: got %0d outputs, first=%0d, want -32768",
               obs_q.size(), (obs_q.size() != 0) ? obs_q[0] : 16'sd0);
    end
  endtask

  task automatic test_capture_toggle();
    do_reset();
    obs_q.delete();
    for (int i = 0; i < 8; i++) run_sample(16'($urandom_range(0, 65535)), 1'b1);
    n_checks++;
    if (obs_q.size() != 8) begin
      n_fail++;
      $display("FAIL toggle_count: got %0d outputs, want 8", obs_q.size());
    end
  endtask

  task automatic test_reset_during_acc();
    run_sample(16'sd20000, 1'b0);
    in = 16'sd7000;
    @(posedge clk);
    @(negedge clk);
    in = ~in;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || out !== 16'sd0) begin
        n_fail++;
        $display("FAIL abort_reset: got out=%0d out_valid=%b, want 0/0", out, out_valid);
      end
    end
    model_clear();
    reset = 1'b0;
    run_sample(16'sd5000, 1'b0);
    run_sample(16'sd5000, 1'b0);
    n_checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 16'sd5000 || obs_q[1] !== 16'sd4995) begin
      n_fail++;
      $display("FAIL abort_restart: got %0d outputs, want 5000 then 4995", obs_q.size());
    end
  endtask

  initial begin : main
    fork
      monitor();
    join_none
    test_reset();
    test_step();
    test_zero();
    test_pos_sat();
    test_neg_sat();
    test_capture_toggle();
    test_reset_during_acc();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d expected samples never produced, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
